// File: rtl/execute_divider.sv
// Iterative radix-2 restoring divider for the execute stage: DIV/DIVU/REM/REMU.
// Stalls the front end while computing and pulses done_o for one cycle with the result.
module execute_divider #(
  parameter int DATA_WIDTH     = 32,
  parameter int REGISTER_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n_i,
  input  logic                      start_e_i,
  input  logic [1:0]                div_op_e_i,
  input  logic [DATA_WIDTH-1:0]     rs1_val_e_i,
  input  logic [DATA_WIDTH-1:0]     rs2_val_e_i,
  input  logic [REGISTER_WIDTH-1:0] rd_e_i,
  input  logic                      flush_i,
  output logic [DATA_WIDTH-1:0]     result_o,
  output logic [REGISTER_WIDTH-1:0] rd_o,
  output logic                      done_o,
  output logic                      busy_o,
  output logic                      stall_o
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST  = CW'(DATA_WIDTH - 1);
  localparam logic [W-1:0]  W_MIN = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t r_state, w_state_next;

  logic [W-1:0]              r_quo, r_rem, r_div, r_result;
  logic [CW-1:0]             r_count;
  logic                      r_is_rem, r_neg_q, r_neg_r;
  logic [REGISTER_WIDTH-1:0] r_rd_cap, r_rd;

  logic          w_signed, w_a_neg, w_b_neg, w_div_zero, w_ovf, w_fast, w_accept;
  logic [W-1:0]  w_a_mag, w_b_mag, w_fast_result;
  logic [W:0]    w_shift;
  logic          w_ge;
  logic [W-1:0]  w_diff_lo, w_rem_next, w_quo_next, w_q_final, w_r_final;
  logic          w_calc_last;

  // Operand decode at capture time
  always_comb begin
    w_signed   = ~div_op_e_i[0];
    w_a_neg    = w_signed & rs1_val_e_i[W-1];
    w_b_neg    = w_signed & rs2_val_e_i[W-1];
    w_a_mag    = w_a_neg ? -rs1_val_e_i : rs1_val_e_i;
    w_b_mag    = w_b_neg ? -rs2_val_e_i : rs2_val_e_i;
    w_div_zero = (rs2_val_e_i == '0);
    w_ovf      = w_signed & (rs1_val_e_i == W_MIN) & (rs2_val_e_i == '1);
    w_fast     = w_div_zero | w_ovf;
    if (w_div_zero)
      w_fast_result = div_op_e_i[1] ? rs1_val_e_i : '1;
    else
      w_fast_result = div_op_e_i[1] ? '0 : W_MIN;
    w_accept   = (r_state == S_IDLE) & start_e_i & ~flush_i;
  end

  // One restoring step; the remainder stays below the divisor, so the low W bits of the difference suffice
  always_comb begin
    w_shift     = {r_rem, r_quo[W-1]};
    w_ge        = (w_shift >= {1'b0, r_div});
    w_diff_lo   = w_shift[W-1:0] - r_div;
    w_rem_next  = w_ge ? w_diff_lo : w_shift[W-1:0];
    w_quo_next  = {r_quo[W-2:0], w_ge};
    w_q_final   = r_neg_q ? -w_quo_next : w_quo_next;
    w_r_final   = r_neg_r ? -w_rem_next : w_rem_next;
    w_calc_last = (r_state == S_CALC) & (r_count == LAST);
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_next = w_fast ? S_DONE : S_CALC;
      S_CALC:  if (w_calc_last) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
    if (flush_i) w_state_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_quo    <= '0;
      r_rem    <= '0;
      r_div    <= '0;
      r_count  <= '0;
      r_is_rem <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_rd_cap <= '0;
      r_rd     <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_quo    <= w_a_mag;
      r_rem    <= '0;
      r_div    <= w_b_mag;
      r_count  <= '0;
      r_is_rem <= div_op_e_i[1];
      r_neg_q  <= w_a_neg ^ w_b_neg;
      r_neg_r  <= w_a_neg;
      r_rd_cap <= rd_e_i;
      if (w_fast) begin
        r_result <= w_fast_result;
        r_rd     <= rd_e_i;
      end
    end else if ((r_state == S_CALC) && !flush_i) begin
      r_quo   <= w_quo_next;
      r_rem   <= w_rem_next;
      r_count <= r_count + 1'b1;
      // Outputs change only on entry to DONE so they hold otherwise
      if (w_calc_last) begin
        r_result <= r_is_rem ? w_r_final : w_q_final;
        r_rd     <= r_rd_cap;
      end
    end
  end

  assign result_o = r_result;
  assign rd_o     = r_rd;
  assign done_o   = (r_state == S_DONE);
  assign busy_o   = (r_state == S_CALC);
  assign stall_o  = rst_n_i & (w_accept | (r_state == S_CALC));

endmodule
